bode_correlator: RTL and testbench
==================================

Name: bode_correlator

Overview:
- Synthesizable lock-in correlator; the stage directly downstream of the Bode-plot excitation generator.
- Consumes the DUT response sample plus the same sin/cos reference the generator drove into the DUT.
- Per measurement, discards a settle window, then accumulates I = Σ resp·cos and Q = Σ resp·sin over 2^LOG2_SAMPLES samples.
- Reports I, Q and an approximate magnitude with a one-cycle result strobe, for the sweep controller and the phase stage.

Parameters:
- DATA_WIDTH, 16: response sample width, signed.
- REF_WIDTH, 16: sin/cos reference width, signed.
- ACC_WIDTH, 48: accumulator/output width, signed. Requires ACC_WIDTH > DATA_WIDTH+REF_WIDTH.
- LOG2_SAMPLES, 10: log2 of the number of accumulated samples (N = 1024).
- SETTLE_SAMPLES, 256: en-qualified samples discarded after start. 0 is legal.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample-valid strobe; inputs are sampled only on edges with en=1.
- start  in  1  begin a measurement; single-cycle pulse.
- response  in  DATA_WIDTH  signed DUT output sample.
- sinRef  in  REF_WIDTH  signed sine reference, aligned with response.
- cosRef  in  REF_WIDTH  signed cosine reference, aligned with response.
- busy  out  1  high from the cycle after an accepted start until resultStrobe.
- resultStrobe  out  1  one-cycle pulse; outputs below are valid from this cycle on.
- iSum  out  ACC_WIDTH  signed Σ response·cosRef.
- qSum  out  ACC_WIDTH  signed Σ response·sinRef.
- mag  out  ACC_WIDTH  unsigned max(|I|,|Q|) + (min(|I|,|Q|)>>1).
- overflow  out  1  either accumulator saturated during the last measurement.

Behaviour:
- Reset (async, rst_n=0): every output is 0, state is IDLE, counters/accumulators/pipeline valid cleared. Reset mid-measurement aborts it with no strobe.
- State IDLE:
  - start=1 → SETTLE (or ACCUM if SETTLE_SAMPLES=0).
  - Accumulators and the sticky overflow bit clear on that edge.
  - Outputs iSum/qSum/mag/overflow hold the previous result.
- State SETTLE: counts en edges. After SETTLE_SAMPLES of them → ACCUM. Samples are not multiplied.
- State ACCUM:
  - Stage 1: on each en edge, register the products pI = response·cosRef and pQ = response·sinRef, full DATA_WIDTH+REF_WIDTH signed, plus valid=1.
  - Stage 2: the next edge adds the sign-extended product into a saturating accumulator.
  - On the edge capturing sample N-1 → FLUSH.
- State FLUSH: one cycle, the final accumulate occurs → DONE.
- State DONE: one cycle.
  - Register iSum, qSum, mag and overflow; assert resultStrobe.
  - Next edge: resultStrobe=0, → IDLE.
- Latency: last sample accepted at edge k; outputs and resultStrobe update at edge k+2.
- Saturation:
  - An accumulator clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) when the true sum exceeds range, and stays clamped unless subsequent adds bring it back.
  - overflow is sticky for the measurement.
- mag:
  - |x| of the most-negative value is taken as 2^(ACC_WIDTH-1)-1.
  - Computed unsigned. No overflow is possible since max+min/2 < 2^ACC_WIDTH.
- en gaps: states and counters hold while en=0; the pipeline still drains.
- start while busy or in DONE: ignored.
- start and en on the same IDLE edge: start accepted; that sample is not counted.
- Sample counter is LOG2_SAMPLES+1 bits wide and does not wrap inside a measurement.

Decomposition:
- Shared package bode_pkg holds:
  - state enum (IDLE, SETTLE, ACCUM, FLUSH, DONE);
  - saturation min/max constant functions parameterised by width;
  - the abs-saturating function used for mag.
- One sub-module, sat_accumulator (clr, add_en, signed operand, saturating signed sum, sticky ovf), instantiated for I and Q.

Test Plan:
1. Hold rst_n=0 with random inputs → all outputs 0, busy=0. Release; start with no en → busy=1 indefinitely, no strobe.
2. DC in-phase, default params, SETTLE=4, en every cycle: response=100, cosRef=1000, sinRef=0 → iSum=102400000, qSum=0, mag=102400000, overflow=0; strobe exactly 2 clk after the 1028th en.
3. Mixed phase, response=-200, cosRef=300, sinRef=400, en every third cycle → iSum=-61440000, qSum=-81920000, mag=81920000+30720000=112640000; single strobe.
4. Saturation, ACC_WIDTH=40, response=32767, cosRef=32767, sinRef=-32768 → iSum=549755813887, qSum=-549755813888, overflow=1, mag=549755813887+274877906943.
5. start pulsed during ACCUM and during DONE → ignored; result identical to scenario 2; exactly one strobe.
6. rst_n asserted mid-ACCUM, released, then scenario 2 rerun → no strobe from the aborted run; correct scenario-2 values.

Source files
------------

// File: rtl/bode_pkg.sv
// Shared types and saturation helpers for the Bode lock-in correlator.
package bode_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    function automatic logic signed [MAX_W-1:0] sat_max(input int w);
        logic signed [MAX_W-1:0] one;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

    // The most-negative value has no positive twin, so it folds onto the maximum.
    function automatic logic signed [MAX_W-1:0] abs_sat(input logic signed [MAX_W-1:0] x,
                                                       input int w);
        if (x <= sat_min(w)) begin
            return sat_max(w);
        end
        if (x < 0) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Saturating signed accumulator with synchronous clear and sticky overflow flag.
module sat_accumulator
    import bode_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        add_en,
    input  logic signed [IN_WIDTH-1:0]  operand,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        ovf
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0]   sum_ext;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic                        ovf_next;

    // One guard bit is enough: the operand is always narrower than the accumulator.
    always_comb begin
        sum_ext  = {sum[ACC_WIDTH-1], sum}
                 + {{(ACC_WIDTH + 1 - IN_WIDTH){operand[IN_WIDTH-1]}}, operand};
        sum_next = sum_ext[ACC_WIDTH-1:0];
        ovf_next = 1'b0;
        if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
            ovf_next = 1'b1;
            sum_next = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            sum <= sum_next;
            ovf <= ovf | ovf_next;
        end
    end

endmodule

// File: rtl/bode_correlator.sv
// Lock-in correlator: settles, then accumulates response*cos and response*sin
// over 2^LOG2_SAMPLES samples and reports I, Q and an approximate magnitude.
module bode_correlator
    import bode_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REF_WIDTH      = 16,
    parameter int ACC_WIDTH      = 48,
    parameter int LOG2_SAMPLES   = 10,
    parameter int SETTLE_SAMPLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] response,
    input  logic [REF_WIDTH-1:0]  sinRef,
    input  logic [REF_WIDTH-1:0]  cosRef,
    output logic                  busy,
    output logic                  resultStrobe,
    output logic [ACC_WIDTH-1:0]  iSum,
    output logic [ACC_WIDTH-1:0]  qSum,
    output logic [ACC_WIDTH-1:0]  mag,
    output logic                  overflow
);

    localparam int PROD_WIDTH = DATA_WIDTH + REF_WIDTH;
    localparam int CNT_WIDTH  = LOG2_SAMPLES + 1;
    localparam int SET_WIDTH  = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_SAMPLE = CNT_WIDTH'((1 << LOG2_SAMPLES) - 1);
    localparam logic [SET_WIDTH-1:0] LAST_SETTLE = SET_WIDTH'(SETTLE_SAMPLES - 1);

    state_t                 state, state_next;
    logic [SET_WIDTH-1:0]   settle_cnt;
    logic [CNT_WIDTH-1:0]   sample_cnt;
    logic                   start_ok, settle_last, sample_take, sample_last;

    logic signed [PROD_WIDTH-1:0] prod_i_p1, prod_q_p1;
    logic                         vld_p1;
    logic signed [ACC_WIDTH-1:0]  sum_i, sum_q;
    logic                         ovf_i, ovf_q;
    logic [ACC_WIDTH-1:0]         abs_i, abs_q, mag_next;

    assign start_ok    = (state == IDLE) && start;
    assign settle_last = (state == SETTLE) && en && (settle_cnt == LAST_SETTLE);
    assign sample_take = (state == ACCUM) && en;
    assign sample_last = sample_take && (sample_cnt == LAST_SAMPLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
            SETTLE:  if (settle_last) state_next = ACCUM;
            ACCUM:   if (sample_last) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
        end else if (start_ok) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
        end else begin
            if ((state == SETTLE) && en) settle_cnt <= settle_cnt + 1'b1;
            if (sample_take)             sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // Stage 1: full-precision products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= sample_take;
    end

    always_ff @(posedge clk) begin
        if (sample_take) begin
            prod_i_p1 <= $signed(response) * $signed(cosRef);
            prod_q_p1 <= $signed(response) * $signed(sinRef);
        end
    end

    // Stage 2: saturating accumulation
    sat_accumulator #(.IN_WIDTH(PROD_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_i (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .add_en(vld_p1),
        .operand(prod_i_p1), .sum(sum_i), .ovf(ovf_i)
    );

    sat_accumulator #(.IN_WIDTH(PROD_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_q (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .add_en(vld_p1),
        .operand(prod_q_p1), .sum(sum_q), .ovf(ovf_q)
    );

    always_comb begin
        abs_i = ACC_WIDTH'(abs_sat(MAX_W'(sum_i), ACC_WIDTH));
        abs_q = ACC_WIDTH'(abs_sat(MAX_W'(sum_q), ACC_WIDTH));
        if (abs_i >= abs_q) mag_next = abs_i + (abs_q >> 1);
        else                mag_next = abs_q + (abs_i >> 1);
    end

    // Result registers: loaded once per measurement, held until the next one completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iSum         <= '0;
            qSum         <= '0;
            mag          <= '0;
            overflow     <= 1'b0;
            resultStrobe <= 1'b0;
        end else begin
            resultStrobe <= (state == DONE);
            if (state == DONE) begin
                iSum     <= sum_i;
                qSum     <= sum_q;
                mag      <= mag_next;
                overflow <= ovf_i | ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_bode_correlator.sv
// Randomised self-checking bench for bode_correlator against a plain-arithmetic reference.
module tb_bode_correlator;

    localparam int N      = 1024;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, start;
    logic [15:0] response, sinRef, cosRef;

    logic        busy, strobe, ovf;
    logic [47:0] i_sum, q_sum, mag;
    logic        busy_s, strobe_s, ovf_s;
    logic [39:0] i_sum_s, q_sum_s, mag_s;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bode_correlator #(.SETTLE_SAMPLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .response(response), .sinRef(sinRef), .cosRef(cosRef),
        .busy(busy), .resultStrobe(strobe), .iSum(i_sum), .qSum(q_sum),
        .mag(mag), .overflow(ovf)
    );

    bode_correlator #(.ACC_WIDTH(40), .SETTLE_SAMPLES(SETTLE)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .response(response), .sinRef(sinRef), .cosRef(cosRef),
        .busy(busy_s), .resultStrobe(strobe_s), .iSum(i_sum_s), .qSum(q_sum_s),
        .mag(mag_s), .overflow(ovf_s)
    );

    longint            prod_i_q[$], prod_q_q[$];
    int                strobe_cnt, strobe_sat_cnt, last_en_edge, strobe_edge;
    logic signed [47:0] obs_i, obs_q;
    logic [47:0]        obs_mag;
    logic               obs_ovf;
    logic signed [39:0] obs_i_s, obs_q_s;
    logic [39:0]        obs_mag_s;
    logic               obs_ovf_s;
    longint             exp_i, exp_q, exp_mag, exp_i_s, exp_q_s, exp_mag_s;
    bit                 exp_ovf, exp_ovf_s;
    bit                 timed_out;
    logic [15:0]        fix_resp, fix_cos, fix_sin;

    task automatic set_sample(input int mode);
        case (mode)
            0: begin response = fix_resp; cosRef = fix_cos; sinRef = fix_sin; end
            1: begin
                response = 16'($urandom); cosRef = 16'($urandom); sinRef = 16'($urandom);
            end
            default: begin
                response = 16'($urandom_range(32767, 30000));
                cosRef   = 16'($urandom_range(32767, 30000));
                sinRef   = 16'(32'd0 - 32'($urandom_range(32768, 30000)));
            end
        endcase
    endtask

    // Reference: skip the settle samples, then saturating sums of the next N products.
    task automatic compute_model(input int w, output longint ei, output longint eq,
                                 output longint em, output bit eo);
        longint one, lo, hi, ai, aq, a, b;
        one = 1;
        lo  = -(one <<< (w - 1));
        hi  = -lo - 1;
        ai  = 0; aq = 0; eo = 0;
        for (int k = SETTLE; k < SETTLE + N && k < prod_i_q.size(); k++) begin
            ai += prod_i_q[k];
            aq += prod_q_q[k];
            if (ai > hi) begin ai = hi; eo = 1; end
            if (ai < lo) begin ai = lo; eo = 1; end
            if (aq > hi) begin aq = hi; eo = 1; end
            if (aq < lo) begin aq = lo; eo = 1; end
        end
        a  = (ai == lo) ? hi : ((ai < 0) ? -ai : ai);
        b  = (aq == lo) ? hi : ((aq < 0) ? -aq : aq);
        ei = ai;
        eq = aq;
        em = (a > b) ? a + (b >> 1) : b + (a >> 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; en = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives one measurement; en_period 0 means random gaps. Call just after an edge.
    task automatic run_measurement(input int mode, input int en_period,
                                   input bit en_on_start, input bit glitch);
        int edge_no, accepted, tail;
        bit done;
        prod_i_q.delete();
        prod_q_q.delete();
        strobe_cnt = 0; strobe_sat_cnt = 0; last_en_edge = -1; strobe_edge = -1;
        timed_out = 0;
        start = 1'b1;
        en    = en_on_start;
        set_sample(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        edge_no = 0; accepted = 0; tail = 0; done = 0;
        while (!done) begin
            if (accepted < SETTLE + N &&
                ((en_period == 0) ? ($urandom_range(2) != 0) : ((edge_no % en_period) == 0))) begin
                en = 1'b1;
                set_sample(mode);
                prod_i_q.push_back(longint'($signed(response)) * longint'($signed(cosRef)));
                prod_q_q.push_back(longint'($signed(response)) * longint'($signed(sinRef)));
                accepted++;
                if (accepted == SETTLE + N) last_en_edge = edge_no + 1;
            end else begin
                en = 1'b0;
            end
            start = glitch && ((accepted == 500) ||
                               (last_en_edge >= 0 && edge_no + 1 == last_en_edge + 2));
            @(posedge clk);
            #1;
            edge_no++;
            if (strobe) begin
                strobe_cnt++;
                if (strobe_edge < 0) begin
                    strobe_edge = edge_no;
                    obs_i = i_sum; obs_q = q_sum; obs_mag = mag; obs_ovf = ovf;
                end
            end
            if (strobe_s) begin
                strobe_sat_cnt++;
                obs_i_s = i_sum_s; obs_q_s = q_sum_s; obs_mag_s = mag_s; obs_ovf_s = ovf_s;
            end
            if (strobe_edge >= 0) tail++;
            if (tail >= 6) done = 1;
            if (edge_no > 8 * (SETTLE + N) + 50) begin
                timed_out = 1;
                done = 1;
            end
        end
        en = 1'b0; start = 1'b0;
        compute_model(48, exp_i, exp_q, exp_mag, exp_ovf);
        compute_model(40, exp_i_s, exp_q_s, exp_mag_s, exp_ovf_s);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            start = 1'($urandom); en = 1'($urandom);
            set_sample(1);
            @(posedge clk);
            #1;
            checks++;
            if ({busy, strobe, ovf, busy_s, strobe_s, ovf_s} !== 6'b0 || i_sum !== '0 ||
                q_sum !== '0 || mag !== '0 || i_sum_s !== '0 || q_sum_s !== '0 || mag_s !== '0) begin
                fails++;
                $display("FAIL reset_outputs: busy=%b strobe=%b iSum=%0d qSum=%0d mag=%0d ovf=%b, required all 0",
                         busy, strobe, i_sum, q_sum, mag, ovf);
            end
        end
        start = 1'b0; en = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (busy !== 1'b1 || strobe !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL start_without_en: %0d cycles not busy or strobing, required 0", bad);
        end
    endtask

    task automatic test_dc_inphase();
        apply_reset();
        fix_resp = 16'd100; fix_cos = 16'd1000; fix_sin = 16'd0;
        run_measurement(0, 1, 1'b0, 1'b0);
        checks++;
        if (timed_out || strobe_cnt != 1) begin
            fails++;
            $display("FAIL dc_strobe_count: got %0d timeout=%0d, required 1", strobe_cnt, timed_out);
        end
        checks++;
        if (strobe_edge - last_en_edge != 2) begin
            fails++;
            $display("FAIL dc_latency: got %0d edges, required 2", strobe_edge - last_en_edge);
        end
        checks++;
        if (obs_i !== 48'sd102400000 || obs_q !== 48'sd0) begin
            fails++;
            $display("FAIL dc_iq: got I=%0d Q=%0d, required I=102400000 Q=0", obs_i, obs_q);
        end
        checks++;
        if (obs_mag !== 48'd102400000 || obs_ovf !== 1'b0) begin
            fails++;
            $display("FAIL dc_mag_ovf: got mag=%0d ovf=%b, required 102400000 0", obs_mag, obs_ovf);
        end
    endtask

    task automatic test_mixed_phase();
        apply_reset();
        fix_resp = 16'(-200); fix_cos = 16'd300; fix_sin = 16'd400;
        run_measurement(0, 3, 1'b0, 1'b0);
        checks++;
        if (timed_out || strobe_cnt != 1 || strobe_edge - last_en_edge != 2) begin
            fails++;
            $display("FAIL mixed_strobe: got count=%0d latency=%0d, required 1 and 2",
                     strobe_cnt, strobe_edge - last_en_edge);
        end
        checks++;
        if (obs_i !== -48'sd61440000 || obs_q !== -48'sd81920000) begin
            fails++;
            $display("FAIL mixed_iq: got I=%0d Q=%0d, required -61440000 -81920000", obs_i, obs_q);
        end
        checks++;
        if (obs_mag !== 48'd112640000 || obs_ovf !== 1'b0) begin
            fails++;
            $display("FAIL mixed_mag: got mag=%0d ovf=%b, required 112640000 0", obs_mag, obs_ovf);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        fix_resp = 16'd32767; fix_cos = 16'd32767; fix_sin = 16'h8000;
        run_measurement(0, 1, 1'b0, 1'b0);
        checks++;
        if (timed_out || strobe_sat_cnt != 1) begin
            fails++;
            $display("FAIL sat_strobe_count: got %0d, required 1", strobe_sat_cnt);
        end
        checks++;
        if (obs_i_s !== 40'sd549755813887 || obs_q_s !== -40'sd549755813888) begin
            fails++;
            $display("FAIL sat_iq: got I=%0d Q=%0d, required 549755813887 -549755813888",
                     obs_i_s, obs_q_s);
        end
        checks++;
        if (obs_ovf_s !== 1'b1 || obs_mag_s !== 40'd824633720830) begin
            fails++;
            $display("FAIL sat_mag_ovf: got mag=%0d ovf=%b, required 824633720830 1",
                     obs_mag_s, obs_ovf_s);
        end
    endtask

    task automatic test_start_ignored();
        apply_reset();
        fix_resp = 16'd100; fix_cos = 16'd1000; fix_sin = 16'd0;
        run_measurement(0, 1, 1'b0, 1'b1);
        checks++;
        if (timed_out || strobe_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch_strobe: got count=%0d busy=%b, required 1 0", strobe_cnt, busy);
        end
        checks++;
        if (obs_i !== 48'sd102400000 || obs_q !== 48'sd0 || obs_mag !== 48'd102400000) begin
            fails++;
            $display("FAIL glitch_values: got I=%0d Q=%0d mag=%0d, required 102400000 0 102400000",
                     obs_i, obs_q, obs_mag);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || i_sum !== 48'd102400000) begin
            fails++;
            $display("FAIL hold_outputs: got busy=%b iSum=%0d, required 1 102400000", busy, i_sum);
        end
    endtask

    task automatic test_abort();
        int aborted_strobes;
        apply_reset();
        fix_resp = 16'd100; fix_cos = 16'd1000; fix_sin = 16'd0;
        aborted_strobes = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        en = 1'b1;
        set_sample(0);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (strobe) aborted_strobes++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || strobe !== 1'b0) begin
            fails++;
            $display("FAIL async_abort: got busy=%b strobe=%b, required 0 0", busy, strobe);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (strobe) aborted_strobes++;
        end
        run_measurement(0, 1, 1'b0, 1'b0);
        checks++;
        if (aborted_strobes != 0 || timed_out || strobe_cnt != 1) begin
            fails++;
            $display("FAIL abort_strobes: got aborted=%0d rerun=%0d, required 0 1",
                     aborted_strobes, strobe_cnt);
        end
        checks++;
        if (obs_i !== 48'sd102400000 || obs_mag !== 48'd102400000 || obs_ovf !== 1'b0) begin
            fails++;
            $display("FAIL abort_rerun: got I=%0d mag=%0d ovf=%b, required 102400000 102400000 0",
                     obs_i, obs_mag, obs_ovf);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            run_measurement((r == 3) ? 2 : 1, 0, 1'($urandom), 1'b0);
            checks++;
            if (timed_out || strobe_cnt != 1 || strobe_edge - last_en_edge != 2) begin
                fails++;
                $display("FAIL rand%0d_strobe: got count=%0d latency=%0d, required 1 2",
                         r, strobe_cnt, strobe_edge - last_en_edge);
            end
            checks++;
            if (obs_i !== 48'(exp_i) || obs_q !== 48'(exp_q) ||
                obs_mag !== 48'(exp_mag) || obs_ovf !== exp_ovf) begin
                fails++;
                $display("FAIL rand%0d_acc48: got I=%0d Q=%0d mag=%0d ovf=%b, required %0d %0d %0d %b",
                         r, obs_i, obs_q, obs_mag, obs_ovf, exp_i, exp_q, exp_mag, exp_ovf);
            end
            checks++;
            if (obs_i_s !== 40'(exp_i_s) || obs_q_s !== 40'(exp_q_s) ||
                obs_mag_s !== 40'(exp_mag_s) || obs_ovf_s !== exp_ovf_s) begin
                fails++;
                $display("FAIL rand%0d_acc40: got I=%0d Q=%0d mag=%0d ovf=%b, required %0d %0d %0d %b",
                         r, obs_i_s, obs_q_s, obs_mag_s, obs_ovf_s,
                         exp_i_s, exp_q_s, exp_mag_s, exp_ovf_s);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; start = 1'b0;
        response = '0; sinRef = '0; cosRef = '0;
        fix_resp = '0; fix_cos = '0; fix_sin = '0;
        #2;
        test_reset();
        test_dc_inphase();
        test_mixed_phase();
        test_saturation();
        test_start_ignored();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
